// File: rtl/vectored_int_ctrl_if.sv
// ---------------------------------------------------------------------------
// vectored_int_ctrl_if
// Groups the interrupt sources, the register bus and the processor
// request/acknowledge handshake of the vectored interrupt controller.
//   irq[3:0]        : external interrupt sources (edge-sensitive)
//   we/addr/wdata   : register write strobe, register select, write data
//   rdata           : register read data (combinational from addr)
//   int_req         : interrupt request to the processor
//   int_vector      : handler address for the current request
//   int_id          : index of the source requested / in service
//   int_ack         : processor took the interrupt (one-cycle pulse)
//   int_done        : processor executed eret (one-cycle pulse)
// master = processor/system side, slave = controller side.
// ---------------------------------------------------------------------------
interface vectored_int_ctrl_if;
    logic [3:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_req;
    logic [31:0] int_vector;
    logic [1:0]  int_id;
    logic        int_ack;
    logic        int_done;

    modport master (
        output irq, we, addr, wdata, int_ack, int_done,
        input  rdata, int_req, int_vector, int_id
    );

    modport slave (
        input  irq, we, addr, wdata, int_ack, int_done,
        output rdata, int_req, int_vector, int_id
    );
endinterface

// File: rtl/vectored_int_ctrl.sv
// ---------------------------------------------------------------------------
// vectored_int_ctrl
// Four-source vectored interrupt controller. Rising edges on irq latch into
// PENDING; the lowest-indexed pending and enabled source is presented to the
// processor as int_req with a handler address VBASE + 16*id. No nesting: a
// new request is only raised from IDLE, after the previous one is done.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of vectored_int_ctrl_if (sources, register bus,
//           processor handshake)
// Register map (addr):
//   0 ENABLE[3:0]  R/W
//   1 PENDING[3:0] read, write-1-to-clear
//   2 VBASE[31:0]  R/W, bits [5:0] read as 0
//   3 STATUS       {28'b0, state[1:0], in_service, int_req}, read-only
// ---------------------------------------------------------------------------
module vectored_int_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    vectored_int_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_irq_q;
    logic [3:0]  r_enable;
    logic [3:0]  r_pending;
    logic [31:0] r_vbase;
    logic        r_int_req;
    logic [31:0] r_int_vector;
    logic [1:0]  r_int_id;
    logic        r_in_service;

    logic [3:0]  w_edge;
    logic [3:0]  w_w1c;
    logic [3:0]  w_ack_clr;
    logic [3:0]  w_pending_next;
    logic [3:0]  w_arb;
    logic [1:0]  w_sel_id;
    logic        w_wr_enable;
    logic        w_wr_vbase;
    logic [31:0] w_rdata;

    assign w_edge      = bus.irq & ~r_irq_q;
    assign w_wr_enable = bus.we && (bus.addr == 2'd0);
    assign w_wr_vbase  = bus.we && (bus.addr == 2'd2);
    assign w_w1c       = (bus.we && (bus.addr == 2'd1)) ? bus.wdata[3:0] : 4'b0000;
    assign w_ack_clr   = ((r_state == ST_REQ) && bus.int_ack) ? (4'b0001 << r_int_id) : 4'b0000;
    assign w_arb       = r_pending & r_enable;

    // A fresh edge wins over any clear of the same bit in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pend
            assign w_pending_next[gi] = w_edge[gi] |
                                        (r_pending[gi] & ~w_w1c[gi] & ~w_ack_clr[gi]);
        end
    endgenerate

    // Fixed priority: lowest index wins (scan downwards, last hit sticks).
    always_comb begin
        w_sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_arb[i]) begin
                w_sel_id = 2'(i);
            end
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (bus.addr)
            2'd0:    w_rdata = {28'h0, r_enable};
            2'd1:    w_rdata = {28'h0, r_pending};
            2'd2:    w_rdata = r_vbase;
            default: w_rdata = {28'h0, r_state, r_in_service, r_int_req};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_irq_q      <= 4'b0000;
            r_enable     <= 4'b0000;
            r_pending    <= 4'b0000;
            r_vbase      <= 32'h0000_0100;
            r_int_req    <= 1'b0;
            r_int_vector <= 32'h0;
            r_int_id     <= 2'd0;
            r_in_service <= 1'b0;
        end else begin
            r_irq_q   <= bus.irq;
            r_pending <= w_pending_next;
            if (w_wr_enable) begin
                r_enable <= bus.wdata[3:0];
            end
            if (w_wr_vbase) begin
                r_vbase <= {bus.wdata[31:6], 6'b000000};
            end

            case (r_state)
                ST_IDLE: begin
                    if (|w_arb) begin
                        r_state      <= ST_REQ;
                        r_int_req    <= 1'b1;
                        r_int_id     <= w_sel_id;
                        // 32-bit add, wraps silently.
                        r_int_vector <= r_vbase + {26'h0, w_sel_id, 4'b0000};
                    end
                end
                ST_REQ: begin
                    // id/vector are frozen here; only ack or a software
                    // clear of the requested bit moves us on.
                    if (bus.int_ack) begin
                        r_state      <= ST_SERVICE;
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                    end else if (!w_pending_next[r_int_id]) begin
                        r_state   <= ST_IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.int_done) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_int_req    <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.int_req    = r_int_req;
    assign bus.int_vector = r_int_vector;
    assign bus.int_id     = r_int_id;
endmodule

// File: tb/tb_vectored_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vectored_int_ctrl
// Directed stimulus against vectored_int_ctrl. Each expected interrupt
// request (id, vector) is pushed into a scoreboard queue when its stimulus
// is issued; an independent monitor pops and compares on every rising edge
// of int_req. Register reads and timing points are checked inline.
// ---------------------------------------------------------------------------
module tb_vectored_int_ctrl;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] vec;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    vectored_int_ctrl_if bus ();

    vectored_int_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rdata, exp);
    endtask

    // Called at a negedge; the write lands on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Called at a negedge while int_req is high: ack, then done.
    task automatic ack_and_done();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
    endtask

    // Scoreboard monitor: compare every new request against the queue head.
    initial begin : monitor
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.int_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got id %0d vector 0x%08h, expected no request",
                             bus.int_id, bus.int_vector);
                end else begin
                    e = exp_q.pop_front();
                    $display("req: id %0d vector 0x%08h (expected id %0d vector 0x%08h)",
                             bus.int_id, bus.int_vector, e.id, e.vec);
                    check("sb_int_id", {30'h0, bus.int_id}, {30'h0, e.id});
                    check("sb_int_vector", bus.int_vector, e.vec);
                end
            end
            prev_req = bus.int_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.irq      = 4'b0;
        bus.we       = 1'b0;
        bus.addr     = 2'd0;
        bus.wdata    = 32'h0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_int_req", {31'h0, bus.int_req}, 32'h0);
        check("rst_int_vector", bus.int_vector, 32'h0);
        check("rst_int_id", {30'h0, bus.int_id}, 32'h0);
        rd_check("rst_vbase", 2'd2, 32'h0000_0100);
        rd_check("rst_status", 2'd3, 32'h0);
        reset = 1'b0;
        tick();

        // Basic flow: source 2, two-edge latency
        wr(2'd0, 32'hF);
        $display("txn: basic flow irq[2]");
        push_exp(2'd2, 32'h0000_0120);
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        check("basic_req_after_1", {31'h0, bus.int_req}, 32'h0);
        rd_check("basic_pending", 2'd1, 32'h4);
        tick();
        check("basic_req_after_2", {31'h0, bus.int_req}, 32'h1);
        check("basic_vector", bus.int_vector, 32'h0000_0120);
        rd_check("basic_status_req", 2'd3, 32'h5);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check("basic_req_after_ack", {31'h0, bus.int_req}, 32'h0);
        rd_check("basic_status_srv", 2'd3, 32'hA);
        rd_check("basic_pending_clr", 2'd1, 32'h0);
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
        rd_check("basic_status_idle", 2'd3, 32'h0);

        // Priority: sources 3 and 1 together
        $display("txn: priority irq[3]+irq[1]");
        push_exp(2'd1, 32'h0000_0110);
        push_exp(2'd3, 32'h0000_0130);
        bus.irq = 4'b1010;
        tick();
        bus.irq = 4'b0000;
        tick();
        check("prio_first_id", {30'h0, bus.int_id}, 32'h1);
        ack_and_done();
        check("prio_idle_gap", {31'h0, bus.int_req}, 32'h0);
        tick();
        check("prio_second_req", {31'h0, bus.int_req}, 32'h1);
        check("prio_second_id", {30'h0, bus.int_id}, 32'h3);
        ack_and_done();

        // Masking: pending while disabled, request once enabled
        $display("txn: masking irq[0]");
        wr(2'd0, 32'h0);
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        repeat (2) tick();
        check("mask_no_req", {31'h0, bus.int_req}, 32'h0);
        rd_check("mask_pending", 2'd1, 32'h1);
        push_exp(2'd0, 32'h0000_0100);
        wr(2'd0, 32'h1);
        tick();
        check("mask_req_after_enable", {31'h0, bus.int_req}, 32'h1);
        check("mask_vector", bus.int_vector, 32'h0000_0100);
        ack_and_done();

        // Collision: new edge on the acked source
        $display("txn: collision irq[1] with ack");
        wr(2'd0, 32'hF);
        push_exp(2'd1, 32'h0000_0110);
        bus.irq = 4'b0010;
        tick();
        bus.irq = 4'b0000;
        tick();
        check("coll_req", {31'h0, bus.int_req}, 32'h1);
        bus.int_ack = 1'b1;
        bus.irq     = 4'b0010;
        tick();
        bus.int_ack = 1'b0;
        bus.irq     = 4'b0000;
        rd_check("coll_pending_kept", 2'd1, 32'h2);
        push_exp(2'd1, 32'h0000_0110);
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
        tick();
        check("coll_rereq", {31'h0, bus.int_req}, 32'h1);
        ack_and_done();

        // VBASE masking and W1C drop of an outstanding request
        $display("txn: vbase write and w1c drop");
        wr(2'd2, 32'h0000_1007);
        rd_check("vbase_low_bits", 2'd2, 32'h0000_1000);
        push_exp(2'd2, 32'h0000_1020);
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        tick();
        check("w1c_req", {31'h0, bus.int_req}, 32'h1);
        wr(2'd1, 32'h4);
        check("w1c_req_dropped", {31'h0, bus.int_req}, 32'h0);
        rd_check("w1c_status", 2'd3, 32'h0);
        rd_check("w1c_pending", 2'd1, 32'h0);
        tick();
        check("w1c_stays_idle", {31'h0, bus.int_req}, 32'h0);

        // Asynchronous reset while in SERVICE
        $display("txn: reset mid-service");
        push_exp(2'd0, 32'h0000_1000);
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        rd_check("srv_status", 2'd3, 32'hA);
        #1;
        reset = 1'b1;
        #1;
        check("arst_int_req", {31'h0, bus.int_req}, 32'h0);
        check("arst_int_vector", bus.int_vector, 32'h0);
        check("arst_int_id", {30'h0, bus.int_id}, 32'h0);
        rd_check("arst_status", 2'd3, 32'h0);
        rd_check("arst_vbase", 2'd2, 32'h0000_0100);
        rd_check("arst_enable", 2'd0, 32'h0);

        // irq already high at reset release counts as an edge
        $display("txn: irq[3] held through reset release");
        bus.irq = 4'b1000;
        tick();
        reset = 1'b0;
        tick();
        rd_check("rel_pending", 2'd1, 32'h8);
        check("rel_no_req", {31'h0, bus.int_req}, 32'h0);
        bus.irq = 4'b0000;
        repeat (2) tick();

        check("sb_queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
